// File: rtl/fp32_to_e4m3_quant_if.sv
// Handshake and statistics bundle for fp32_to_e4m3_quant.
// The master side feeds words and drains results; the slave side is the quantizer.
interface fp32_to_e4m3_quant_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits;
  logic [7:0]  io_scale_exp;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_out_bits;
  logic        io_amax_clear;
  logic [31:0] io_amax;
  logic [15:0] io_sat_count;

  modport master (
    output io_in_valid, io_in_bits, io_scale_exp, io_out_ready, io_amax_clear,
    input  io_in_ready, io_out_valid, io_out_bits, io_amax, io_sat_count
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_scale_exp, io_out_ready, io_amax_clear,
    output io_in_ready, io_out_valid, io_out_bits, io_amax, io_sat_count
  );
endinterface

// File: rtl/fp32_to_e4m3_quant.sv
// FP32 -> FP8 E4M3 with pow2 scale, RNE and +/-448 saturation; QUANT_STATS_EN adds amax/sat-count stats.
// Latency 2 cycles at 1 word/cycle; io_in_ready drops only when both stages hold data and io_out_ready is low.
module fp32_to_e4m3_quant (
  input  logic                clock,
  input  logic                reset,
  fp32_to_e4m3_quant_if.slave io
);
  logic              r_s1_vld;
  logic              r_s1_sign;
  logic              r_s1_nan;
  logic              r_s1_inf;
  logic              r_s1_zero;
  logic signed [9:0] r_s1_e;
  logic [22:0]       r_s1_man;
  logic              r_s2_vld;
  logic [7:0]        r_s2_bits;
  logic              r_s2_sat;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_hs;
  logic [7:0]        w_in_exp;
  logic [22:0]       w_in_man;
  logic              w_in_nan;
  logic signed [9:0] w_in_e;

  assign w_s2_adv = !r_s2_vld || io.io_out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign w_in_hs  = io.io_in_valid && w_s1_adv;

  assign w_in_exp = io.io_in_bits[30:23];
  assign w_in_man = io.io_in_bits[22:0];
  assign w_in_nan = (&w_in_exp) && (|w_in_man);
  assign w_in_e   = $signed({2'b00, w_in_exp}) - 10'sd127
                  + $signed({{2{io.io_scale_exp[7]}}, io.io_scale_exp});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_vld <= io.io_in_valid;
    end
    if (w_in_hs) begin
      r_s1_sign <= io.io_in_bits[31];
      r_s1_nan  <= w_in_nan;
      r_s1_inf  <= (&w_in_exp) && !(|w_in_man);
      r_s1_zero <= !(|w_in_exp);
      r_s1_e    <= w_in_e;
      r_s1_man  <= w_in_man;
    end
  end

  logic        w_q_sat;
  logic [7:0]  w_q_code;
  logic        w_up;
  logic [3:0]  w_eb;
  logic [7:0]  w_norm;
  logic [2:0]  w_sh;
  logic [27:0] w_y;
  logic [3:0]  w_sub;

  // Mantissa carry ripples into the exponent field, so {exp, man} + round is the rounded code.
  always_comb begin
    w_q_code = {r_s1_sign, 7'h00};
    w_q_sat  = 1'b0;
    w_up     = 1'b0;
    w_eb     = r_s1_e[3:0] + 4'd7;
    w_norm   = 8'h00;
    w_sh     = 3'd2 - r_s1_e[2:0];
    w_y      = {1'b1, r_s1_man, 4'b0000} >> w_sh;
    w_sub    = 4'h0;
    if (r_s1_nan) begin
      w_q_code = {r_s1_sign, 7'h7F};
    end else if (r_s1_inf) begin
      w_q_code = {r_s1_sign, 7'h7E};
      w_q_sat  = 1'b1;
    end else if (r_s1_zero || (r_s1_e < -10'sd10)) begin
      w_q_code = {r_s1_sign, 7'h00};
    end else if (r_s1_e > 10'sd8) begin
      w_q_code = {r_s1_sign, 7'h7E};
      w_q_sat  = 1'b1;
    end else if (r_s1_e >= -10'sd6) begin
      w_up   = r_s1_man[19] && ((|r_s1_man[18:0]) || r_s1_man[20]);
      w_norm = {1'b0, w_eb, r_s1_man[22:20]} + {7'd0, w_up};
      if (w_norm >= 8'h7F) begin
        w_q_code = {r_s1_sign, 7'h7E};
        w_q_sat  = 1'b1;
      end else begin
        w_q_code = {r_s1_sign, w_norm[6:0]};
      end
    end else begin
      // Subnormal: integer part lands in w_y[27:24], guard at [23], sticky below.
      w_up     = w_y[23] && ((|w_y[22:0]) || w_y[24]);
      w_sub    = w_y[27:24] + {3'd0, w_up};
      w_q_code = {r_s1_sign, 3'b000, w_sub};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_bits <= 8'h00;
      r_s2_sat  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_bits <= w_q_code;
        r_s2_sat  <= w_q_sat;
      end
    end
  end

  assign io.io_in_ready  = w_s1_adv;
  assign io.io_out_valid = r_s2_vld;
  assign io.io_out_bits  = r_s2_bits;

`ifdef QUANT_STATS_EN
  logic [31:0] r_amax;
  logic [15:0] r_sat_cnt;
  logic [31:0] w_abs;
  logic        w_amax_upd;
  logic        w_sat_hs;

  assign w_abs      = {1'b0, io.io_in_bits[30:0]};
  assign w_amax_upd = w_in_hs && !w_in_nan;
  assign w_sat_hs   = r_s2_vld && io.io_out_ready && r_s2_sat;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_amax    <= 32'h0;
      r_sat_cnt <= 16'h0;
    end else if (io.io_amax_clear) begin
      r_amax    <= w_amax_upd ? w_abs : 32'h0;
      r_sat_cnt <= w_sat_hs ? 16'd1 : 16'd0;
    end else begin
      if (w_amax_upd && (w_abs > r_amax)) r_amax <= w_abs;
      if (w_sat_hs && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign io.io_amax      = r_amax;
  assign io.io_sat_count = r_sat_cnt;
`else
  logic w_unused;
  assign w_unused        = io.io_amax_clear ^ r_s2_sat;
  assign io.io_amax      = 32'h0;
  assign io.io_sat_count = 16'h0;
`endif
endmodule
